// File: rtl/wam_pkg.sv
// Shared types and widths for the whack-a-mole round controller.
package wam_pkg;

    localparam int WAM_DIFF_W  = 4;
    localparam int WAM_SCORE_W = 12;
    localparam int WAM_TIME_W  = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        OVER   = 3'd4
    } wam_state_t;

endpackage

// File: rtl/wam_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// Holds its count while en is low; clr zeroes it and takes priority.
module wam_tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wam_round_ctrl.sv
// Round controller for the whack-a-mole core: clear, play, pause, time-out, high score.
// Define WAM_RAMP_EN to raise the difficulty every RAMP_SEC seconds of play.
module wam_round_ctrl
    import wam_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int ROUND_SEC  = 60,
    parameter int CLR_CYCLES = 2_097_152,
    parameter int RAMP_SEC   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_start,
    input  logic                   btn_pause,
    input  logic [1:0]             diff_sel,
    input  logic [WAM_SCORE_W-1:0] score,
    output logic                   start,
    output logic                   pause,
    output logic [WAM_DIFF_W-1:0]  difficulty,
    output logic [WAM_TIME_W-1:0]  time_left,
    output logic                   game_over,
    output logic [WAM_SCORE_W-1:0] high_score,
    output logic [2:0]             state
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [WAM_TIME_W-1:0] ROUND_LOAD = WAM_TIME_W'(ROUND_SEC);

    if ((ROUND_SEC < 1) || (ROUND_SEC > 99) || (RAMP_SEC < 1) || (CLR_CYCLES < 1)) begin : g_bad_cfg
        $error("wam_round_ctrl: parameter out of range");
    end

    wam_state_t            cur_state;
    wam_state_t            nxt_state;
    logic [CLR_W-1:0]      clr_cnt;
    logic [WAM_DIFF_W-1:0] diff_load;
    logic                  tick;
    logic                  tick_en;
    logic                  tick_clr;
    logic                  entering_clear;
    logic                  entering_over;

    assign tick_en        = (cur_state == PLAY);
    assign tick_clr       = (cur_state == CLEAR);
    assign entering_clear = (nxt_state == CLEAR) && (cur_state != CLEAR);
    assign entering_over  = (nxt_state == OVER) && (cur_state != OVER);
    assign state          = cur_state;

    wam_tick_gen #(
        .DIV (CLK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        diff_load           = '0;
        diff_load[diff_sel] = 1'b1;
    end

    // Priority inside PLAY: restart beats expiry, expiry beats pause.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (btn_start) nxt_state = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) nxt_state = PLAY;
            end
            PLAY: begin
                if (btn_start)
                    nxt_state = CLEAR;
                else if (tick && (time_left == WAM_TIME_W'(1)))
                    nxt_state = OVER;
                else if (btn_pause)
                    nxt_state = PAUSED;
            end
            PAUSED: begin
                if (btn_start)
                    nxt_state = CLEAR;
                else if (btn_pause)
                    nxt_state = PLAY;
            end
            OVER: begin
                if (btn_start) nxt_state = CLEAR;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            start     <= 1'b0;
            pause     <= 1'b1;
            game_over <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            start     <= (nxt_state == CLEAR);
            pause     <= (nxt_state != PLAY);
            game_over <= (nxt_state == OVER);
            clr_cnt   <= ((cur_state == CLEAR) && (nxt_state == CLEAR)) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_left <= ROUND_LOAD;
        end else if (entering_clear) begin
            time_left <= ROUND_LOAD;
        end else if (tick) begin
            time_left <= time_left - 1'b1;
        end
    end

    // BCD digits order the same as binary, so a plain compare picks the best score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_score <= '0;
        end else if (entering_over && (score > high_score)) begin
            high_score <= score;
        end
    end

`ifdef WAM_RAMP_EN
    localparam int RAMP_W = (RAMP_SEC > 1) ? $clog2(RAMP_SEC) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_SEC - 1);

    logic [RAMP_W-1:0] ramp_cnt;
    logic              ramp_step;

    assign ramp_step = tick && (ramp_cnt == RAMP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_cnt <= '0;
        end else if (cur_state == CLEAR) begin
            ramp_cnt <= '0;
        end else if (tick) begin
            ramp_cnt <= ramp_step ? '0 : ramp_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            difficulty <= WAM_DIFF_W'(1);
        end else if (entering_clear) begin
            difficulty <= diff_load;
        end
`ifdef WAM_RAMP_EN
        else if (ramp_step && !difficulty[WAM_DIFF_W-1]) begin
            difficulty <= difficulty << 1;
        end
`endif
    end

endmodule

// File: doc/wam_round_ctrl.md
# wam_round_ctrl

Round controller for the whack-a-mole game. It sequences one timed round of the mole core: it clears the core, releases it, counts the round down in seconds, freezes it on pause or at time-out, and latches the high score. It sits between the debounced board buttons/switches and the core's `start`, `pause` and `difficulty` inputs. It reads the core's 12-bit BCD `score` back.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock frequency; the 1 s tick prescaler divides by this.
- `ROUND_SEC`, 60: round length in seconds, 1..99.
- `CLR_CYCLES`, 2_097_152: length of the `start` clear pulse. It must cover at least two periods of the core's slow mole clock.
- `RAMP_SEC`, 15: seconds per difficulty step. Used only with `WAM_RAMP_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_start` in 1: single-cycle pulse, already debounced.
- `btn_pause` in 1: single-cycle pulse that toggles pause.
- `diff_sel` in 2: difficulty selection, 0=easy .. 3=hard.
- `score` in 12: 3-digit BCD score from the core.
- `start` out 1: clear to the core.
- `pause` out 1: freeze to the core.
- `difficulty` out 4: one-hot difficulty to the core.
- `time_left` out 7: remaining seconds, binary.
- `game_over` out 1: high in OVER.
- `high_score` out 12: best BCD score since reset.
- `state` out 3: FSM state, for the display.

## Operation
- State encodings: IDLE=0, CLEAR=1, PLAY=2, PAUSED=3, OVER=4.
- IDLE:
  - Outputs: `pause`=1, `start`=0, `time_left`=ROUND_SEC.
  - `btn_start` moves to CLEAR.
- CLEAR:
  - `start`=1 and `pause`=1 for exactly CLR_CYCLES cycles.
  - On entry, `difficulty` is loaded as 1<<diff_sel, `time_left` is set to ROUND_SEC, and the prescaler and ramp counter are zeroed.
  - After CLR_CYCLES cycles, moves to PLAY.
- PLAY:
  - Outputs: `start`=0, `pause`=0.
  - On each tick (prescaler reaching CLK_HZ-1), `time_left` decrements.
  - When a tick occurs with `time_left`==1, `time_left` becomes 0 and the state moves to OVER.
  - `btn_pause` moves to PAUSED.
  - `btn_start` restarts the round by going to CLEAR.
- PAUSED:
  - Outputs: `pause`=1. The prescaler holds its value and does not reset.
  - `btn_pause` returns to PLAY.
  - `btn_start` moves to CLEAR.
- OVER:
  - Outputs: `pause`=1, `game_over`=1.
  - On the entry cycle, if `score` > `high_score`, `high_score` is loaded with `score`. A plain unsigned compare is valid because the values are BCD.
  - `btn_start` moves to CLEAR.
- `diff_sel` is sampled only on CLEAR entry. Changes during a round are ignored.
- Simultaneous events:
  - Expiry tick and `btn_pause` in the same cycle: OVER wins.
  - `btn_start` and `btn_pause` in the same cycle: `btn_start` wins.
- `high_score` survives rounds and is cleared only by `rst_n`.

## Timing
- Reset values: state IDLE, `start`=0, `pause`=1, `difficulty`=4'b0001, `time_left`=ROUND_SEC, `game_over`=0, `high_score`=0, prescaler 0.
- All outputs are registered. Each responds one cycle after the qualifying input edge.
- `start` rises on the cycle after `btn_start` and stays high for exactly CLR_CYCLES cycles. `pause` falls on the cycle `start` falls.
- The first decrement occurs CLK_HZ cycles after PLAY entry, excluding paused cycles.
- A full round lasts ROUND_SEC*CLK_HZ play cycles from PLAY entry to OVER.
- If `rst_n` is asserted mid-round, all registers return to reset values immediately, without waiting for a clock edge.

## Configuration
- `WAM_RAMP_EN` defined:
  - In PLAY, a ramp counter counts ticks. Every RAMP_SEC ticks, `difficulty` shifts left by one, saturating at 4'b1000.
  - The counter freezes in PAUSED and clears in CLEAR.
- `WAM_RAMP_EN` undefined:
  - `difficulty` stays at its CLEAR-entry value for the whole round.
  - No ramp counter is instantiated.

## Structure
- Package `wam_pkg` holds:
  - the state enum `wam_state_t` (encodings above);
  - `WAM_DIFF_W`=4;
  - `WAM_SCORE_W`=12;
  - `WAM_TIME_W`=7.
- Sub-module `wam_tick_gen`: the prescaler. It has inputs `clk`, `rst_n`, `en`, `clr` and a one-cycle `tick` output. It is reusable by the display blinker.
- The FSM, timer, ramp counter and high-score register stay in the top module.

## Test plan
All scenarios use CLK_HZ=10, ROUND_SEC=3, CLR_CYCLES=4, RAMP_SEC=1.
- Reset, then `btn_start` with `diff_sel`=2:
  - `start` is high for exactly 4 cycles and `difficulty`=4'b0100.
  - `pause` falls with `start`, and the state reaches PLAY.
- Uninterrupted round:
  - `time_left` steps 3→2→1→0 at 10-cycle intervals.
  - OVER and `game_over`=1 are reached 30 cycles after PLAY entry.
- Pause for 25 cycles at `time_left`=2: `time_left` is frozen and `pause`=1 during the pause. OVER is reached exactly 25 cycles later than in an unpaused round.
- Scores across rounds:
  - First round ends with `score`=12'h045: `high_score`=12'h045.
  - Next round ends with 12'h039: `high_score` is unchanged.
  - Next round ends with 12'h101: `high_score`=12'h101.
- Collisions:
  - `btn_pause` on the expiry tick: the state goes to OVER, not PAUSED.
  - `btn_start` in PLAY: the state goes to CLEAR and `time_left` reloads to 3.
- With `WAM_RAMP_EN`, `diff_sel`=1:
  - `difficulty` steps 0010→0100→1000 and then holds at 1000.
  - `rst_n` low mid-round returns all outputs to their reset values asynchronously.
